mac_operand_feeder: RTL

- Buffers one A/B operand vector pair, up to DEPTH entries, then streams it into the downstream MAC stage one pair per cycle.
- Terminates each vector with a one-cycle finished strobe so the MAC latches its accumulated dot product onto C_out.
- Drives zeros whenever not streaming; the MAC accumulates on every non-finished cycle, so idle zeros leave its sum unchanged.
- Sits directly upstream of the MAC in each systolic row. An optional leading zero-skew staggers rows.

---
 rtl/mac_operand_feeder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mac_operand_feeder.sv
// Operand feeder for one systolic MAC row: buffers an A/B vector, then streams it with a finished strobe.
// Optional leading zero-skew stage is compiled in with `define FEEDER_SKEW_EN.
module mac_operand_feeder #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned SKEW   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_a,
   input  logic [DATA_W-1:0] wr_b,
   input  logic              wr_last,
   input  logic              start,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic              a_finished,
   output logic              b_finished,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      S_LOAD   = 3'd0,
      S_READY  = 3'd1,
`ifdef FEEDER_SKEW_EN
      S_SKEW   = 3'd2,
`endif
      S_STREAM = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [CW-1:0]     len, len_nxt;
   logic [CW-1:0]     rd_idx, rd_nxt;
   logic [DATA_W-1:0] a_nxt, b_nxt;
   logic              fin_nxt;
   logic              busy_nxt;

   logic [DATA_W-1:0] mem_a [DEPTH];
   logic [DATA_W-1:0] mem_b [DEPTH];

`ifdef FEEDER_SKEW_EN
   localparam int unsigned SW        = (SKEW > 1) ? $clog2(SKEW) : 1;
   localparam logic [SW-1:0] SKEW_LAST = SW'((SKEW > 0) ? (SKEW - 1) : 0);
   logic [SW-1:0] skew_cnt, skew_nxt;
`else
   // SKEW has no effect unless the skew stage is compiled in
   if (SKEW != 0) begin : g_skew_ignored
   end
`endif

   assign wr_ready = (state == S_LOAD);

   // Operand buffer; contents survive across vectors and resets
   always_ff @(posedge clk) begin
      if ((state == S_LOAD) && wr_valid) begin
         mem_a[AW'(cnt)] <= wr_a;
         mem_b[AW'(cnt)] <= wr_b;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      len_nxt   = len;
      rd_nxt    = rd_idx;
      a_nxt     = '0;
      b_nxt     = '0;
      fin_nxt   = 1'b0;
`ifdef FEEDER_SKEW_EN
      skew_nxt  = skew_cnt;
`endif
      case (state)
         S_LOAD: begin
            if (wr_valid) begin
               cnt_nxt = cnt + CW'(1);
               if (wr_last || (cnt_nxt == CW'(DEPTH))) begin
                  state_nxt = S_READY;
                  len_nxt   = cnt_nxt;
               end
            end
         end
         S_READY: begin
            if (start) begin
`ifdef FEEDER_SKEW_EN
               if (SKEW > 0) begin
                  state_nxt = S_SKEW;
                  skew_nxt  = '0;
               end else
`endif
               begin
                  state_nxt = S_STREAM;
                  rd_nxt    = '0;
                  a_nxt     = mem_a[0];
                  b_nxt     = mem_b[0];
               end
            end
         end
`ifdef FEEDER_SKEW_EN
         S_SKEW: begin
            if (skew_cnt == SKEW_LAST) begin
               state_nxt = S_STREAM;
               rd_nxt    = '0;
               a_nxt     = mem_a[0];
               b_nxt     = mem_b[0];
            end else begin
               skew_nxt = skew_cnt + SW'(1);
            end
         end
`endif
         S_STREAM: begin
            // Registered outputs present the entry for the next cycle
            if (rd_idx == (len - CW'(1))) begin
               state_nxt = S_FINISH;
               fin_nxt   = 1'b1;
            end else begin
               rd_nxt = rd_idx + CW'(1);
               a_nxt  = mem_a[AW'(rd_nxt)];
               b_nxt  = mem_b[AW'(rd_nxt)];
            end
         end
         S_FINISH: begin
            state_nxt = S_LOAD;
            cnt_nxt   = '0;
            rd_nxt    = '0;
         end
         default: begin
            state_nxt = S_LOAD;
         end
      endcase

      busy_nxt = (state_nxt == S_STREAM) || (state_nxt == S_FINISH);
`ifdef FEEDER_SKEW_EN
      if (state_nxt == S_SKEW) begin
         busy_nxt = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_LOAD;
         cnt        <= '0;
         len        <= '0;
         rd_idx     <= '0;
         a_out      <= '0;
         b_out      <= '0;
         a_finished <= 1'b0;
         b_finished <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         len        <= len_nxt;
         rd_idx     <= rd_nxt;
         a_out      <= a_nxt;
         b_out      <= b_nxt;
         a_finished <= fin_nxt;
         b_finished <= fin_nxt;
         done       <= fin_nxt;
         busy       <= busy_nxt;
      end
   end

`ifdef FEEDER_SKEW_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skew_cnt <= '0;
      end else begin
         skew_cnt <= skew_nxt;
      end
   end
`endif

endmodule
